dff_ontransit_burst: RTL
========================

// Module: dff_ontransit_burst
// PURPOSE
// - Parametrised burst controller; all outputs registered on the transition taken (dff-ontransit).
// - Tracks a request level 'do': step pulse per active RUN cycle, done pulse on burst exit.
// - Adds a run-length limit with overflow, a post-burst cooldown and a step counter.
// - Sits between a request source and a downstream sequencer that consumes s/g pulses.
// PARAMETERS
// - CNT_W    8   width of cnt; MAX_RUN <= 2**CNT_W-1 is a legal-configuration requirement.
// - MAX_RUN  16  max s pulses per burst (>=1); reaching it forces exit with ovf.
// - COOL_CYC 2   cooldown cycles after LAST (>=0); 0 means LAST goes straight to IDLE.
// PORTS
// - clk      in   1      clock, rising edge
// - rst_n    in   1      asynchronous, active-low reset
// - do       in   1      burst request level
// - abort    in   1      abort request (only with BURST_ABORT_EN)
// - g        out  1      done pulse, 1 cycle, on leaving RUN
// - s        out  1      step pulse, 1 cycle per RUN cycle with do
// - ovf      out  1      pulse coincident with g when exit was forced by MAX_RUN
// - busy     out  1      high while FSM is not in IDLE (registered)
// - cnt      out  CNT_W  s pulses in current/most recent burst
// - aborted  out  1      abort pulse (only with BURST_ABORT_EN)
// BEHAVIOUR
// - Reset: state=IDLE; g=s=ovf=busy=aborted=0; cnt=0; cool counter=0.
// - Outputs: registered from nx_* values computed in the transition block.
// - nx_* defaults to 0 each cycle except cnt, which holds.
// - Latency: each output changes at the edge that commits the transition causing it.
// - States: IDLE, RUN, LAST, COOL.
// - IDLE: do=1 -> RUN, cnt<=0; else stay.
// - RUN, do=1, cnt<MAX_RUN: stay RUN, nx_s=1, cnt<=cnt+1.
// - RUN, do=1, cnt==MAX_RUN: -> LAST, nx_g=1, nx_ovf=1; no s; cnt holds.
// - RUN, do=0: -> LAST, nx_g=1; cnt holds.
// - LAST: -> COOL (cool counter loaded with COOL_CYC-1) if COOL_CYC>0, else -> IDLE; do ignored.
// - COOL: counter decrements each cycle; at 0 -> IDLE; do ignored.
// - Re-entry from IDLE requires do sampled high in IDLE.
// - busy: nx_busy=(nextstate!=IDLE).
// - cnt: never wraps; bounded by MAX_RUN. Cleared only on IDLE->RUN or reset; holds after burst.
// - Reset mid-burst: all outputs clear asynchronously; no g generated.
// - Unreachable state encodings recover to IDLE on the next clock.
// CONFIGURATION
// - BURST_ABORT_EN defined: abort port and aborted output exist.
//   - abort=1 in RUN/LAST/COOL -> IDLE next edge; nx_aborted=1; nx_g=nx_s=nx_ovf=0.
//   - abort has priority over do and the MAX_RUN limit; cnt holds.
//   - abort ignored in IDLE.
// - BURST_ABORT_EN undefined: neither port exists; behaviour exactly as above.
// TESTING
// - Reset: rst_n low with do=1 -> g=s=ovf=busy=0, cnt=0, FSM stays IDLE while rst_n=0.
// - Normal burst: do=1 for 4 cycles from IDLE, then 0 (defaults) ->
//   busy rises; s high 3 cycles with cnt=1,2,3; g pulses once with ovf=0;
//   busy falls 3 edges after g (LAST + 2 COOL).
// - Overflow: do held 1 for 25 cycles, MAX_RUN=16 ->
//   16 s pulses, cnt=16; g and ovf together; no s in LAST/COOL; new burst with cnt=0 once IDLE.
// - COOL_CYC=0 build: same stimulus as normal burst -> busy falls 1 edge after g; do=1 in LAST ignored.
// - Async reset mid-RUN at cnt=5 -> cnt=0, busy=0, s=0 immediately, no g pulse.
// - BURST_ABORT_EN: abort=1 for one cycle in RUN with do=1 at cnt=3 ->
//   aborted=1 for one cycle; g=ovf=0; busy=0 after that edge; cnt stays 3.

Source files
------------

// File: rtl/dff_ontransit_burst.sv
// Burst controller: step pulse per active RUN cycle, done/overflow pulse on exit, post-burst cooldown.
// Optional abort feature enabled by defining BURST_ABORT_EN; request level port is do_req ('do' is reserved).
module dff_ontransit_burst #(
    parameter int CNT_W    = 8,
    parameter int MAX_RUN  = 16,
    parameter int COOL_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             do_req,
`ifdef BURST_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             g,
    output logic             s,
    output logic             ovf,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam int COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t              state, nx_state;
    logic [COOL_W-1:0]   cool, nx_cool;
    logic                nx_g, nx_s, nx_ovf, nx_busy, nx_aborted;
    logic [CNT_W-1:0]    nx_cnt;

    always_comb begin
        nx_state   = state;
        nx_cool    = cool;
        nx_g       = 1'b0;
        nx_s       = 1'b0;
        nx_ovf     = 1'b0;
        nx_aborted = 1'b0;
        nx_cnt     = cnt;
        case (state)
            IDLE: begin
                if (do_req) begin
                    nx_state = RUN;
                    nx_cnt   = '0;
                end
            end
            RUN: begin
                if (!do_req) begin
                    nx_state = LAST;
                    nx_g     = 1'b1;
                end else if (cnt >= MAX_CNT) begin
                    nx_state = LAST;
                    nx_g     = 1'b1;
                    nx_ovf   = 1'b1;
                end else begin
                    nx_s   = 1'b1;
                    nx_cnt = cnt + 1'b1;
                end
            end
            LAST: begin
                if (COOL_CYC > 0) begin
                    nx_state = COOL;
                    nx_cool  = COOL_LOAD;
                end else begin
                    nx_state = IDLE;
                end
            end
            COOL: begin
                if (cool == '0) nx_state = IDLE;
                else            nx_cool  = cool - 1'b1;
            end
            default: nx_state = IDLE;
        endcase
`ifdef BURST_ABORT_EN
        // Abort overrides every RUN/LAST/COOL decision above, including the MAX_RUN exit.
        if (abort && state != IDLE) begin
            nx_state   = IDLE;
            nx_g       = 1'b0;
            nx_s       = 1'b0;
            nx_ovf     = 1'b0;
            nx_aborted = 1'b1;
            nx_cnt     = cnt;
        end
`endif
        nx_busy = (nx_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cool  <= '0;
            g     <= 1'b0;
            s     <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
`ifdef BURST_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            state <= nx_state;
            cool  <= nx_cool;
            g     <= nx_g;
            s     <= nx_s;
            ovf   <= nx_ovf;
            busy  <= nx_busy;
            cnt   <= nx_cnt;
`ifdef BURST_ABORT_EN
            aborted <= nx_aborted;
`endif
        end
    end

`ifndef BURST_ABORT_EN
    logic unused_nx_aborted;
    assign unused_nx_aborted = nx_aborted;
`endif

endmodule
